univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal register: a WIDTH-bit register with synchronous clear/set, parallel load, shift/rotate modes and a multi-cycle burst-shift engine with busy/done handshake. It is the general-purpose successor to the single-bit set/reset flip-flop in the sequential-logic library. It is used wherever a datapath needs a loadable, shiftable holding register (serializers, barrel-shift-by-iteration, scratch registers).

## Interface
- WIDTH, 8, register width; legal range ≥ 2.
- RST_VAL, {WIDTH{1'b0}}, value of q after rst.
- CNT_W, $clog2(WIDTH+1) (derived, localparam), width of the burst count.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, asynchronous, active-high.
- en  in  1  enable for single-step operations and for burst start.
- clr  in  1  synchronous clear, q ← 0.
- set  in  1  synchronous set, q ← all ones.
- mode  in  3  operation select (see Operation).
- d  in  WIDTH  parallel load data.
- sin_lsb  in  1  serial bit entering bit 0 on SHL.
- sin_msb  in  1  serial bit entering bit WIDTH-1 on SHR.
- start  in  1  request a burst of amt steps in the current shift/rotate mode.
- amt  in  CNT_W  burst length in steps.
- q  out  WIDTH  register contents.
- sout_msb  out  1  q[WIDTH-1], combinational from q.
- sout_lsb  out  1  q[0], combinational from q.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.

## Operation
- Modes: 0 HOLD, 1 LOAD (q←d), 2 SHL (q←{q[W-2:0],sin_lsb}), 3 SHR (q←{sin_msb,q[W-1:1]}), 4 ROTL, 5 ROTR, 6 ASR (q←{q[W-1],q[W-1:1]}), 7 reserved, behaves as HOLD.
- Priority each edge: rst (async) > clr > set > active burst > en-gated single step.
- Idle (busy=0), en=1, start=0: one step of mode. en=0: hold, start ignored.
- Burst accept: busy=0, en=1, start=1, mode ∈ {2..6}, amt>0 → latch mode and counter=amt, busy←1; no shift on the accept edge.
- Burst run: each subsequent edge performs one step of the latched mode, counter decrements; en, mode, d, start ignored; sin_lsb/sin_msb sampled live each step.
- Last step edge (counter 1→0): busy←0, done←1 for exactly one cycle.
- start with amt=0 and a shift mode: no busy, done pulses next cycle, q unchanged.
- start with mode 0, 1 or 7: treated as a single step, no busy, no done.
- amt > WIDTH is legal: shifts saturate to fill, rotates wrap modulo WIDTH.
- clr or set while busy: applied, burst aborted, busy←0, no done pulse.
- Reset values: q=RST_VAL, busy=0, done=0, counter=0; rst mid-burst aborts with no done.

## Timing
- Single step/load/clr/set: visible on q one edge after sampled.
- Burst of N≥1: accept at edge T; q updates at T+1..T+N; busy high for cycles T+1..T+N; done high in cycle T+N+1 only... (done asserted by edge T+N, deasserted by edge T+N+1).
- Back-to-back: new start accepted on the edge where done is high (busy already 0).
- sout_msb/sout_lsb: zero-cycle from q.

## Configuration
- UNIV_SHREG_PARITY_EN defined: extra output parity (1 bit) = registered even parity of next-q, valid same cycle as q; reset value = ^RST_VAL.
- Undefined: no parity port, no parity logic.

## Structure
- Package shreg_pkg: shreg_mode_e enum (3-bit mode codes above) and helper function for one-step next-value given mode, q, serial inputs.
- One sub-module: shreg_burst_ctl (counter, busy, done, latched mode, abort input); top holds the data register and priority mux.

## Test plan
- WIDTH=8: rst=1 → q=8'h00, busy=0, done=0; release, LOAD d=8'hA5, en=1 → q=8'hA5 next edge.
- q=8'hA5, SHL sin_lsb=1 single step → 8'h4B; ROTR → 8'hA5 back; ASR on 8'h80 → 8'hC0.
- q=8'h81, start, ROTL, amt=3 → busy 3 cycles, q 8'h03, 8'h06, 8'h0C, done pulse one cycle after.
- Burst SHR amt=5, assert clr in 3rd busy cycle → q=0, busy=0, no done.
- start with amt=0 mode SHL → q unchanged, done one cycle, busy never high; start with mode LOAD → single load, no done.
- clr and set together → q=0; set alone → 8'hFF; rst mid-burst → q=RST_VAL immediately, busy=0.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// Shared types and the one-step next-value helper for the universal shift register.
package shreg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROTL = 3'd4,
        MODE_ROTR = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_RSVD = 3'd7
    } shreg_mode_e;

    // Helper operates on a fixed-width container; callers cast to/from their own width.
    localparam int unsigned SHREG_MAX_W = 256;

    function automatic logic is_shift_mode(input shreg_mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) ||
               (m == MODE_ROTR) || (m == MODE_ASR);
    endfunction

    // One step of mode on a w-bit value held in the low bits of v (upper bits must be zero).
    function automatic logic [SHREG_MAX_W-1:0] shreg_step(
        input shreg_mode_e             mode,
        input logic [SHREG_MAX_W-1:0]  v,
        input logic [SHREG_MAX_W-1:0]  d,
        input logic                    sin_lsb,
        input logic                    sin_msb,
        input int unsigned             w
    );
        logic [SHREG_MAX_W-1:0] mask;
        logic [SHREG_MAX_W-1:0] lsb;
        logic [SHREG_MAX_W-1:0] msb;
        logic [SHREG_MAX_W-1:0] r;
        mask = (SHREG_MAX_W'(1) << w) - SHREG_MAX_W'(1);
        lsb  = v & SHREG_MAX_W'(1);
        msb  = (v >> (w - 1)) & SHREG_MAX_W'(1);
        case (mode)
            MODE_LOAD: r = d;
            MODE_SHL:  r = (v << 1) | SHREG_MAX_W'(sin_lsb);
            MODE_SHR:  r = (v >> 1) | (SHREG_MAX_W'(sin_msb) << (w - 1));
            MODE_ROTL: r = (v << 1) | msb;
            MODE_ROTR: r = (v >> 1) | (lsb << (w - 1));
            MODE_ASR:  r = (v >> 1) | (msb << (w - 1));
            default:   r = v;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register.
// Optional parity output present when UNIV_SHREG_PARITY_EN is defined.
interface univ_shift_reg_if
    import shreg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) ();

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic              en;
    logic              clr;
    logic              set;
    shreg_mode_e       mode;
    logic [WIDTH-1:0]  d;
    logic              sin_lsb;
    logic              sin_msb;
    logic              start;
    logic [CNT_W-1:0]  amt;
    logic [WIDTH-1:0]  q;
    logic              sout_msb;
    logic              sout_lsb;
    logic              busy;
    logic              done;
`ifdef UNIV_SHREG_PARITY_EN
    logic              parity;

    modport master (
        output en, clr, set, mode, d, sin_lsb, sin_msb, start, amt,
        input  q, sout_msb, sout_lsb, busy, done, parity
    );
    modport slave (
        input  en, clr, set, mode, d, sin_lsb, sin_msb, start, amt,
        output q, sout_msb, sout_lsb, busy, done, parity
    );
`else
    modport master (
        output en, clr, set, mode, d, sin_lsb, sin_msb, start, amt,
        input  q, sout_msb, sout_lsb, busy, done
    );
    modport slave (
        input  en, clr, set, mode, d, sin_lsb, sin_msb, start, amt,
        output q, sout_msb, sout_lsb, busy, done
    );
`endif

endinterface

// File: rtl/univ_shift_reg_burst_ctl.sv
// Burst engine: step counter, latched mode, busy/done handshake with abort.
module shreg_burst_ctl
    import shreg_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_req,
    input  logic [CNT_W-1:0]  amt,
    input  shreg_mode_e       mode,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output shreg_mode_e       run_mode
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    shreg_mode_e       mode_n;
    logic              done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            run_mode <= MODE_HOLD;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            run_mode <= mode_n;
            done     <= done_n;
        end
    end

    // A zero-length request completes immediately; abort drops the burst silently.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mode_n  = run_mode;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    if (amt == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = ST_RUN;
                        cnt_n   = amt;
                        mode_n  = mode;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: clear/set, load, shift/rotate and burst shifting.
// Define UNIV_SHREG_PARITY_EN to add a registered even-parity output.
module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic              clk,
    input logic              rst,
    univ_shift_reg_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q, q_next;
    logic [WIDTH-1:0] step_live, step_run;
    logic             shift_req, abort, start_req;
    logic             busy, done;
    shreg_mode_e      run_mode;

    assign step_live = WIDTH'(shreg_step(bus.mode, SHREG_MAX_W'(q), SHREG_MAX_W'(bus.d),
                                         bus.sin_lsb, bus.sin_msb, WIDTH));
    assign step_run  = WIDTH'(shreg_step(run_mode, SHREG_MAX_W'(q), SHREG_MAX_W'(bus.d),
                                         bus.sin_lsb, bus.sin_msb, WIDTH));

    // A shift-mode start is a burst request and never steps on its own edge.
    assign shift_req = bus.en && bus.start && is_shift_mode(bus.mode);
    assign abort     = bus.clr || bus.set;
    assign start_req = shift_req && !busy && !abort;

    shreg_burst_ctl #(
        .CNT_W (CNT_W)
    ) u_burst_ctl (
        .clk       (clk),
        .rst       (rst),
        .start_req (start_req),
        .amt       (bus.amt),
        .mode      (bus.mode),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .run_mode  (run_mode)
    );

    // Priority: clr > set > running burst > enabled single step.
    always_comb begin
        q_next = q;
        if (bus.clr) begin
            q_next = '0;
        end else if (bus.set) begin
            q_next = '1;
        end else if (busy) begin
            q_next = step_run;
        end else if (bus.en && !shift_req) begin
            q_next = step_live;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= q_next;
        end
    end

`ifdef UNIV_SHREG_PARITY_EN
    logic parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity <= ^RST_VAL;
        end else begin
            parity <= ^q_next;
        end
    end

    assign bus.parity = parity;
`endif

    assign bus.q        = q;
    assign bus.sout_msb = q[WIDTH-1];
    assign bus.sout_lsb = q[0];
    assign bus.busy     = busy;
    assign bus.done     = done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=8.
module tb_univ_shift_reg;
    import shreg_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    univ_shift_reg_if #(.WIDTH(8)) bus ();

    univ_shift_reg #(
        .WIDTH   (8),
        .RST_VAL (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        chk8({tag, "_q"}, bus.q, eq);
        chk1({tag, "_busy"}, bus.busy, eb);
        chk1({tag, "_done"}, bus.done, ed);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.clr     = 1'b0;
        bus.set     = 1'b0;
        bus.mode    = MODE_HOLD;
        bus.d       = 8'h00;
        bus.sin_lsb = 1'b0;
        bus.sin_msb = 1'b0;
        bus.start   = 1'b0;
        bus.amt     = 4'd0;
        tick();
        chk_state("reset", 8'h00, 1'b0, 1'b0);
        chk1("reset_sout_lsb", bus.sout_lsb, 1'b0);
        rst = 1'b0;

        // single-step operations
        bus.en = 1'b1; bus.mode = MODE_LOAD; bus.d = 8'hA5;
        tick();
        chk8("load_a5", bus.q, 8'hA5);
        chk1("sout_msb_a5", bus.sout_msb, 1'b1);
        chk1("sout_lsb_a5", bus.sout_lsb, 1'b1);
        bus.mode = MODE_SHL; bus.sin_lsb = 1'b1;
        tick();
        chk8("shl_4b", bus.q, 8'h4B);
        bus.mode = MODE_ROTR; bus.sin_lsb = 1'b0;
        tick();
        chk8("rotr_a5", bus.q, 8'hA5);
        bus.mode = MODE_LOAD; bus.d = 8'h80;
        tick();
        bus.mode = MODE_ASR;
        tick();
        chk8("asr_c0", bus.q, 8'hC0);
        bus.mode = MODE_RSVD;
        tick();
        chk8("rsvd_hold", bus.q, 8'hC0);

        // en low: hold and ignore start
        bus.en = 1'b0; bus.mode = MODE_SHL; bus.start = 1'b1; bus.amt = 4'd2;
        tick();
        chk_state("en0_hold", 8'hC0, 1'b0, 1'b0);
        bus.start = 1'b0;

        // ROTL burst of 3 on 0x81
        bus.en = 1'b1; bus.mode = MODE_LOAD; bus.d = 8'h81;
        tick();
        bus.mode = MODE_ROTL; bus.start = 1'b1; bus.amt = 4'd3;
        tick();
        chk_state("rotl_acc", 8'h81, 1'b1, 1'b0);
        bus.start = 1'b0; bus.en = 1'b0; bus.mode = MODE_HOLD;
        tick();
        chk_state("rotl_s1", 8'h03, 1'b1, 1'b0);
        tick();
        chk_state("rotl_s2", 8'h06, 1'b1, 1'b0);
        tick();
        chk_state("rotl_s3", 8'h0C, 1'b0, 1'b1);
        tick();
        chk_state("rotl_post", 8'h0C, 1'b0, 1'b0);

        // SHR burst of 5 aborted by clr in the third busy cycle
        bus.en = 1'b1; bus.mode = MODE_LOAD; bus.d = 8'hF0;
        tick();
        bus.mode = MODE_SHR; bus.sin_msb = 1'b1; bus.start = 1'b1; bus.amt = 4'd5;
        tick();
        chk_state("shr_acc", 8'hF0, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();
        chk_state("shr_s1", 8'hF8, 1'b1, 1'b0);
        tick();
        chk_state("shr_s2", 8'hFC, 1'b1, 1'b0);
        bus.clr = 1'b1;
        tick();
        chk_state("shr_clr", 8'h00, 1'b0, 1'b0);
        bus.clr = 1'b0; bus.en = 1'b0;
        tick();
        chk_state("shr_nodone", 8'h00, 1'b0, 1'b0);

        // zero-length burst
        bus.en = 1'b1; bus.mode = MODE_LOAD; bus.d = 8'h3C; bus.sin_msb = 1'b0;
        tick();
        bus.mode = MODE_SHL; bus.start = 1'b1; bus.amt = 4'd0;
        tick();
        chk_state("amt0", 8'h3C, 1'b0, 1'b1);
        bus.start = 1'b0; bus.en = 1'b0;
        tick();
        chk_state("amt0_post", 8'h3C, 1'b0, 1'b0);

        // start with a non-shift mode is a plain step
        bus.en = 1'b1; bus.mode = MODE_LOAD; bus.d = 8'h5A; bus.start = 1'b1; bus.amt = 4'd2;
        tick();
        chk_state("start_load", 8'h5A, 1'b0, 1'b0);
        bus.start = 1'b0; bus.en = 1'b0;
        tick();
        chk_state("start_load_post", 8'h5A, 1'b0, 1'b0);

        // clr beats set; set alone fills ones
        bus.clr = 1'b1; bus.set = 1'b1;
        tick();
        chk8("clr_set", bus.q, 8'h00);
        bus.clr = 1'b0;
        tick();
        chk8("set_ff", bus.q, 8'hFF);
        bus.set = 1'b0;

        // ROTR burst of 9 wraps to one position
        bus.en = 1'b1; bus.mode = MODE_LOAD; bus.d = 8'h01;
        tick();
        bus.mode = MODE_ROTR; bus.start = 1'b1; bus.amt = 4'd9;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk_state("rotr9_s8", 8'h01, 1'b1, 1'b0);
        tick();
        chk_state("rotr9_end", 8'h80, 1'b0, 1'b1);

        // back-to-back start accepted while done is high
        bus.mode = MODE_ROTL; bus.start = 1'b1; bus.amt = 4'd1;
        tick();
        chk_state("b2b_acc", 8'h80, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();
        chk_state("b2b_end", 8'h01, 1'b0, 1'b1);

        // async reset mid-burst
        bus.mode = MODE_SHL; bus.sin_lsb = 1'b1; bus.start = 1'b1; bus.amt = 4'd4;
        tick();
        bus.start = 1'b0;
        tick();
        chk_state("rstb_s1", 8'h03, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_state("rst_mid", 8'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        bus.en = 1'b0;
        tick();
        chk_state("rst_after", 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
